// File: rtl/ysyx_210247_pipe_buf.sv
// Elastic pipeline-stage buffer. It is a small circular FIFO that sits between
// two pipeline stages and uses the valid/allow handshake on both sides. The
// upstream allow is taken from registered occupancy only, so it does not carry
// a combinational path back from the downstream allow.
module ysyx_210247_pipe_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_allow,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_allow,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] entry [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly at DEPTH-1, so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign in_allow  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign out_data  = entry[rd_ptr];
    assign count     = cnt;
    assign push      = in_valid & in_allow;
    assign pop       = out_valid & out_allow;

    // Update the pointers and occupancy. A flush empties the buffer and drops any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage is cleared only by reset. A flush leaves stale words in place, and they stay unreachable until they are overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (push && !flush) begin
            entry[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_ysyx_210247_pipe_buf.sv
// Directed bench for the elastic stage buffer. Three instances (DEPTH 2, 3 and 4)
// are checked against a queue scoreboard on every cycle.
module tb_ysyx_210247_pipe_buf;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush     [3];
    logic         in_valid  [3];
    logic [W-1:0] in_data   [3];
    logic         in_allow  [3];
    logic         out_valid [3];
    logic [W-1:0] out_data  [3];
    logic         out_allow [3];
    logic [3:0]   count     [3];
    int           dep       [3] = '{2, 3, 4};

    int ntests = 0;
    int nfail  = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : 4;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cnt;
        ysyx_210247_pipe_buf #(.WIDTH(W), .DEPTH(D)) dut (
            .clk(clk), .rst(rst), .flush(flush[g]),
            .in_valid(in_valid[g]), .in_data(in_data[g]), .in_allow(in_allow[g]),
            .out_valid(out_valid[g]), .out_data(out_data[g]), .out_allow(out_allow[g]),
            .count(cnt)
        );
        assign count[g] = 4'(cnt);

        // Occupancy invariant: count is bounded by D and agrees with the pointer distance.
        always @(negedge clk) begin
            if (rst) begin
                int diff;
                diff = (int'(dut.wr_ptr) - int'(dut.rd_ptr) + D) % D;
                ntests++;
                assert ((int'(cnt) <= D) && ((int'(cnt) == D) ? (dut.wr_ptr == dut.rd_ptr) : (int'(cnt) == diff)))
                else begin
                    nfail++;
                    $error("FAIL inv%0d: count=%0d wr=%0d rd=%0d", g, cnt, dut.wr_ptr, dut.rd_ptr);
                end
            end
        end
    end

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [W-1:0] qfront(int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(int i, logic [W-1:0] d);
        case (i)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qpop(int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qclear(int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(string tag, int i, logic [W-1:0] obs, logic [W-1:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s[%0d]: got %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic drive(int i, logic v, logic [W-1:0] d, logic oa, logic fl);
        in_valid[i]  = v;
        in_data[i]   = d;
        out_allow[i] = oa;
        flush[i]     = fl;
    endtask

    // One clock: check every instance mid-cycle, then advance the scoreboard at the edge.
    task automatic tick();
        bit psh [3];
        bit pp  [3];
        #4;
        for (int i = 0; i < 3; i++) begin
            int sz;
            if (!rst) qclear(i);
            sz = qsize(i);
            chk("out_valid", i, W'(out_valid[i]), W'(sz != 0));
            chk("in_allow", i, W'(in_allow[i]), W'(sz != dep[i]));
            chk("count", i, W'(count[i]), W'(sz));
            if (!rst) chk("rst_data", i, out_data[i], '0);
            else if (sz != 0) chk("out_data", i, out_data[i], qfront(i));
            psh[i] = in_valid[i] && (sz != dep[i]);
            pp[i]  = (sz != 0) && out_allow[i];
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst || flush[i]) begin
                qclear(i);
            end else begin
                if (pp[i]) qpop(i);
                if (psh[i]) qpush(i, in_data[i]);
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Hold reset low for 3 cycles with a word offered on instance 0.
        drive(0, 1'b1, 64'hDEAD, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        drive(0, 1'b1, 64'hA5, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        #4;
        chk("first_word", 0, out_data[0], 64'hA5);
        chk("first_cnt", 0, W'(count[0]), W'(1));
        #(-0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Streaming through the DEPTH=2 instance, one word per cycle.
        for (int k = 1; k <= 10; k++) begin
            drive(0, 1'b1, W'(k), 1'b1, 1'b0);
            tick();
        end
        chk("stream_cnt", 0, W'(count[0]), W'(1));
        drive(0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Fill the DEPTH=4 instance under backpressure.
        for (int k = 1; k <= 4; k++) begin
            drive(2, 1'b1, W'(k * 'h11), 1'b0, 1'b0);
            tick();
        end
        drive(2, 1'b1, 64'h55, 1'b0, 1'b0);
        tick();
        chk("full_cnt", 2, W'(count[2]), W'(4));
        chk("full_allow", 2, W'(in_allow[2]), W'(0));
        drive(2, 1'b1, 64'h55, 1'b1, 1'b0);
        tick();
        drive(2, 1'b1, 64'h55, 1'b0, 1'b0);
        tick();
        drive(2, 1'b0, '0, 1'b1, 1'b0);
        repeat (5) tick();
        drive(2, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // DEPTH=2 full with a simultaneous pop: the push is refused.
        drive(0, 1'b1, 64'h21, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, 64'h22, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, 64'h23, 1'b1, 1'b0);
        tick();
        chk("fullpop_cnt", 0, W'(count[0]), W'(1));
        drive(0, 1'b1, 64'h24, 1'b1, 1'b0);
        tick();
        chk("pushpop_cnt", 0, W'(count[0]), W'(1));
        drive(0, 1'b0, '0, 1'b1, 1'b0);
        repeat (2) tick();
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Pointer wrap on the DEPTH=3 instance.
        for (int k = 0; k < 7; k++) begin
            drive(1, 1'b1, W'('h100 + k), 1'b1, 1'b0);
            tick();
        end
        drive(1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Flush with a word offered and a pop requested in the same cycle.
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1'b1, W'('h30 + k), 1'b0, 1'b0);
            tick();
        end
        drive(1, 1'b1, 64'h77, 1'b1, 1'b1);
        tick();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("flush_cnt", 1, W'(count[1]), W'(0));
        drive(1, 1'b1, 64'h88, 1'b0, 1'b0);
        tick();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        #4;
        chk("after_flush", 1, out_data[1], 64'h88);
        @(posedge clk);
        #1;
        drive(1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Reset asserted mid-operation clears everything.
        drive(2, 1'b1, 64'h61, 1'b0, 1'b0);
        tick();
        drive(2, 1'b1, 64'h62, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        drive(2, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
